spi_sram_master: RTL and testbench
==================================

# spi_sram_master

Byte-oriented SPI master for an external 23LC512-class serial SRAM, operating in sequential mode. It sits directly downstream of the tile's request sequencer. It accepts a single-cycle read or write strobe with an address and write data, then runs one complete SPI transaction: chip-select, command, address and data. The read result is presented on a parallel bus, and `busy` tells the sequencer when the result is ready or a new request may be issued.

## Interface
- `DATA_WIDTH_BYTES`, default 1: bytes transferred per transaction, 1..4.
- `ADDR_BITS`, default 16: address length on the wire, 16 or 24. Must be a multiple of 8.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `spi_miso` input, 1 bit: serial data from the SRAM.
- `spi_select` output, 1 bit: chip select, active low.
- `spi_clk_out` output, 1 bit: SCK, SPI mode 0, frequency clk/2.
- `spi_mosi` output, 1 bit: serial data to the SRAM.
- `addr_in` input, ADDR_BITS: transaction address.
- `data_in` input, 8*DATA_WIDTH_BYTES: write data.
- `start_read` input, 1 bit: single-cycle read request.
- `start_write` input, 1 bit: single-cycle write request.
- `data_out` output, 8*DATA_WIDTH_BYTES: last read result.
- `busy` output, 1 bit: transaction in progress.

## Operation
**Reset values** (all registered outputs):
- `spi_select`=1, `spi_clk_out`=0, `spi_mosi`=0, `busy`=0, `data_out`=0, state IDLE.

**States:** IDLE → SHIFT → CS_HOLD → IDLE.
- **IDLE**
  - Outputs hold their reset levels, except `data_out`, which keeps its last value.
  - On a start strobe:
    - Capture `addr_in`, `data_in` and the direction.
    - Load the shift register with {command, address, payload}.
    - Go to SHIFT.
  - Command byte: write = 0x02, read = 0x03.
  - If `start_write` and `start_read` are both high, the write wins and the read is dropped.
- **SHIFT**
  - Transfers B = 8 + ADDR_BITS + 8*DATA_WIDTH_BYTES bits, MSB first within each field.
  - Each bit takes 2 cycles:
    - Low phase: SCK=0, with MOSI already holding the bit.
    - High phase: SCK=1.
  - Payload order: byte 0 (`data_in[7:0]`) goes first, then byte 1, and so on. Each byte is sent MSB first.
  - Reads:
    - During the payload bits, `spi_miso` is sampled on the edge that raises SCK.
    - Sampled bits are assembled in the same byte order: the first byte received lands in `data_out[7:0]`.
    - The address phase is unaffected.
  - During the payload bits of a read, `spi_mosi` is driven 0.
  - After the high phase of bit B-1: `spi_select`←1, SCK←0, MOSI←0, go to CS_HOLD.
  - On a read, `data_out` is updated with the full assembled word on this same edge. Partial data is never visible on `data_out`.
- **CS_HOLD**
  - Lasts one cycle, guaranteeing CS-high time.
  - Then `busy`←0 and the state returns to IDLE.
- **Write transactions** never change `data_out`.
- **Start strobes while `busy`=1** are ignored. They are not queued.
- **`addr_in`/`data_in` changes after the start edge** have no effect on the running transaction.
- **Reset during a transaction:** asynchronous return to the reset values. `spi_select` goes high immediately, no further SCK edges occur, and the transaction is abandoned.

## Timing
- E0 is the clk edge that samples the start strobe. At E0: `busy`←1, `spi_select`←0, SCK←0, MOSI←command MSB.
- SCK rises at E0+1, E0+3, …, E0+2B-1 and falls at E0+2, …, E0+2B.
- At E0+2B: `spi_select`←1, and read data is valid on `data_out`.
- At E0+2B+1: `busy`←0. `busy` is high for exactly 2B+1 cycles; `spi_select` is low for exactly 2B cycles.
- A new strobe is accepted at the first edge where `busy`=0. Back-to-back transactions give a minimum CS-high time of 2 cycles.
- Defaults (ADDR_BITS=16, DATA_WIDTH_BYTES=1): B=32, so `busy` lasts 65 cycles.

## Test plan
- **Write:** `start_write`, `addr_in`=0x1234, `data_in`=0xA5 → MOSI decodes as 0x02,0x12,0x34,0xA5 over 32 SCK rises. `busy` is high for 65 cycles and `data_out` stays unchanged.
- **Read:** `start_read`, `addr_in`=0x1234, SRAM model returns 0x5A → MOSI decodes as 0x03,0x12,0x34. `data_out`=0x5A at E0+64 and `busy` falls at E0+65.
- **Multi-byte read:** DATA_WIDTH_BYTES=2, model returns 0x11 then 0x22 → `data_out`=0x2211. For DATA_WIDTH_BYTES=2 a read has B=40: `data_out` is valid at E0+80 and `busy` falls at E0+81.
- **Contention:**
  - Both starts on the same edge → a write transaction runs.
  - `start_read` pulsed mid-write → ignored, and exactly one CS-low window is observed.
- **Reset mid-read:** assert `rst_n`=0 at bit 20 → `spi_select`=1 and `busy`=0 asynchronously, `data_out`=0. A subsequent read completes normally.
- **Back-to-back:** issue a read on the first edge with `busy`=0 after a write → CS is high for ≥2 cycles, and both transactions decode correctly.

Source files
------------

// File: rtl/spi_sram_master.sv
// spi_sram_master: SPI mode-0 master (SCK = clk/2) running one sequential-mode 23LC512 read/write per strobe
// ports: clk, rst_n (async active-low); spi_miso/spi_select/spi_clk_out/spi_mosi to the SRAM;
//        addr_in, data_in, start_read, start_write from the sequencer; data_out (last read word), busy
module spi_sram_master #(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ADDR_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_miso,
  output logic spi_select,
  output logic spi_clk_out,
  output logic spi_mosi,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
  input  logic start_read,
  input  logic start_write,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic busy
);
  localparam int DW = 8*DATA_WIDTH_BYTES;
  localparam int B = 8 + ADDR_BITS + DW;
  localparam int CW = $clog2(B);
  localparam logic [CW-1:0] LAST = CW'(B-1);
  localparam logic [CW-1:0] PAY = CW'(8+ADDR_BITS);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, CS_HOLD = 2'd2;
  logic [1:0] state;
  logic [B-1:0] sr, frame;
  logic [DW-1:0] rx, tx_sw, rx_sw;
  logic [CW-1:0] cnt;
  logic rd;
  // byte 0 travels first on the wire in both directions, so the payload is byte-reversed
  always_comb begin
    tx_sw = '0;
    rx_sw = '0;
    for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
      tx_sw[8*(DATA_WIDTH_BYTES-1-k) +: 8] = data_in[8*k +: 8];
      rx_sw[8*k +: 8] = rx[8*(DATA_WIDTH_BYTES-1-k) +: 8];
    end
  end
  // read payload is shifted as zeros so MOSI idles low while the SRAM talks
  assign frame = {start_write ? 8'h02 : 8'h03, addr_in, start_write ? tx_sw : {DW{1'b0}}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      spi_select <= 1'b1;
      spi_clk_out <= 1'b0;
      spi_mosi <= 1'b0;
      busy <= 1'b0;
      data_out <= '0;
      sr <= '0;
      rx <= '0;
      cnt <= '0;
      rd <= 1'b0;
    end else
      case (state)
        IDLE: if (start_write || start_read) begin
          state <= SHIFT;
          busy <= 1'b1;
          spi_select <= 1'b0;
          spi_mosi <= frame[B-1];
          sr <= {frame[B-2:0], 1'b0};
          cnt <= '0;
          rd <= !start_write;
        end
        SHIFT: if (!spi_clk_out) begin
          spi_clk_out <= 1'b1;
          if (rd && cnt >= PAY) rx <= {rx[DW-2:0], spi_miso};
        end else if (cnt == LAST) begin
          state <= CS_HOLD;
          spi_select <= 1'b1;
          spi_clk_out <= 1'b0;
          spi_mosi <= 1'b0;
          if (rd) data_out <= rx_sw;
        end else begin
          spi_clk_out <= 1'b0;
          spi_mosi <= sr[B-1];
          sr <= {sr[B-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        CS_HOLD: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_spi_sram_master.sv
// tb_spi_sram_master: randomized self-checking bench with a serial SRAM model for 1- and 2-byte masters
module tb_spi_sram_master;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic miso1 = 1'b0, sel1, sck1, mosi1, busy1, rd1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic [7:0] din1 = '0, dout1;
  logic miso2 = 1'b0, sel2, sck2, mosi2, busy2, rd2 = 1'b0, wr2 = 1'b0;
  logic [15:0] addr2 = '0, din2 = '0, dout2;
  spi_sram_master u1 (.clk(clk), .rst_n(rst_n), .spi_miso(miso1), .spi_select(sel1), .spi_clk_out(sck1),
    .spi_mosi(mosi1), .addr_in(addr1), .data_in(din1), .start_read(rd1), .start_write(wr1),
    .data_out(dout1), .busy(busy1));
  spi_sram_master #(.DATA_WIDTH_BYTES(2)) u2 (.clk(clk), .rst_n(rst_n), .spi_miso(miso2), .spi_select(sel2),
    .spi_clk_out(sck2), .spi_mosi(mosi2), .addr_in(addr2), .data_in(din2), .start_read(rd2),
    .start_write(wr2), .data_out(dout2), .busy(busy2));
  int n_chk = 0, n_fail = 0;
  logic [7:0] resp1 = '0;
  logic [15:0] resp2 = '0;
  bit q1[$];
  int rises1 = 0, rises2 = 0, windows1 = 0;
  // SRAM model: records MOSI on SCK rise, presents the next read-payload bit right after each rise
  always @(negedge sel1 or posedge sck1) begin
    if (sck1) begin
      if (!sel1) q1.push_back(mosi1);
      rises1++;
    end else begin
      rises1 = 0;
      windows1++;
    end
    miso1 = (rises1 >= 24 && rises1 < 32) ? resp1[31-rises1] : 1'b0;
  end
  always @(negedge sel2 or posedge sck2) begin
    int j;
    rises2 = sck2 ? rises2 + 1 : 0;
    j = rises2 - 24;
    miso2 = (j >= 0 && j < 16) ? resp2[8*(j/8) + 7 - (j%8)] : 1'b0;
  end
  task automatic run1(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d, input bit mid_read,
                      input string nm);
    logic [7:0] old, expd;
    logic [31:0] got, expw;
    int bcnt, scnt, k, s0, w0;
    old = dout1;
    expd = (!w && r) ? resp1 : old;
    expw = {w ? 8'h02 : 8'h03, a, w ? d : 8'h00};
    s0 = q1.size();
    w0 = windows1;
    wr1 = w; rd1 = r; addr1 = a; din1 = d;
    @(negedge clk);
    wr1 = 1'b0; rd1 = 1'b0; addr1 = 16'($urandom); din1 = 8'($urandom);
    bcnt = 0; scnt = 0; k = 0;
    forever begin
      if (mid_read) rd1 = (k == 30);
      if (busy1) bcnt++;
      if (!sel1) scnt++;
      if (k == 63) begin
        n_chk++;
        if (dout1 !== old) begin n_fail++; $display("FAIL %s early_data: got %h want %h", nm, dout1, old); end
      end
      if (k == 64) begin
        n_chk++;
        if (dout1 !== expd) begin n_fail++; $display("FAIL %s data_out: got %h want %h", nm, dout1, expd); end
        n_chk++;
        if (sel1 !== 1'b1) begin n_fail++; $display("FAIL %s cs_rise: got %b want 1", nm, sel1); end
      end
      if (k == 65) begin
        n_chk++;
        if (sel1 !== 1'b1 || busy1 !== 1'b0) begin
          n_fail++; $display("FAIL %s cs_hold: sel %b busy %b want 1 0", nm, sel1, busy1);
        end
      end
      if (!busy1 || k == 200) break;
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (bcnt != 65) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want 65", nm, bcnt); end
    n_chk++;
    if (scnt != 64) begin n_fail++; $display("FAIL %s cs_low_cycles: got %0d want 64", nm, scnt); end
    n_chk++;
    if (windows1 - w0 != 1) begin n_fail++; $display("FAIL %s cs_windows: got %0d want 1", nm, windows1 - w0); end
    got = '0;
    for (int i = s0; i < q1.size() && i < s0 + 32; i++) got = {got[30:0], q1[i]};
    n_chk++;
    if (q1.size() - s0 != 32 || got !== expw) begin
      n_fail++; $display("FAIL %s mosi: got %h (%0d bits) want %h (32 bits)", nm, got, q1.size() - s0, expw);
    end
  endtask
  task automatic run2(input logic [15:0] a, input logic [15:0] rsp, input string nm);
    logic [15:0] old;
    int bcnt, k;
    old = dout2;
    resp2 = rsp;
    rd2 = 1'b1; addr2 = a;
    @(negedge clk);
    rd2 = 1'b0; addr2 = 16'($urandom);
    bcnt = 0; k = 0;
    forever begin
      if (busy2) bcnt++;
      if (k == 79) begin
        n_chk++;
        if (dout2 !== old) begin n_fail++; $display("FAIL %s early_data: got %h want %h", nm, dout2, old); end
      end
      if (k == 80) begin
        n_chk++;
        if (dout2 !== rsp || sel2 !== 1'b1) begin
          n_fail++; $display("FAIL %s data_out: got %h sel %b want %h sel 1", nm, dout2, sel2, rsp);
        end
      end
      if (!busy2 || k == 200) break;
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (bcnt != 81 || k != 81) begin n_fail++; $display("FAIL %s busy_cycles: got %0d fall %0d want 81", nm, bcnt, k); end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sel1, sck1, mosi1, busy1} !== 4'b1000 || dout1 !== 8'h00) begin
      n_fail++; $display("FAIL reset1: sel/sck/mosi/busy %b%b%b%b dout %h want 1000 00", sel1, sck1, mosi1, busy1, dout1);
    end
    n_chk++;
    if ({sel2, sck2, mosi2, busy2} !== 4'b1000 || dout2 !== 16'h0) begin
      n_fail++; $display("FAIL reset2: sel/sck/mosi/busy %b%b%b%b dout %h want 1000 0000", sel2, sck2, mosi2, busy2, dout2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_write;
    run1(1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0, "write_fixed");
    repeat (3) run1(1'b1, 1'b0, 16'($urandom), 8'($urandom), 1'b0, "write_rand");
  endtask
  task automatic test_read;
    resp1 = 8'h5A;
    run1(1'b0, 1'b1, 16'h1234, 8'($urandom), 1'b0, "read_fixed");
    repeat (3) begin
      resp1 = 8'($urandom);
      run1(1'b0, 1'b1, 16'($urandom), 8'($urandom), 1'b0, "read_rand");
    end
  endtask
  task automatic test_reset_mid_read;
    int t, s0, r0;
    resp1 = 8'($urandom);
    s0 = q1.size();
    t = 0;
    rd1 = 1'b1; addr1 = 16'($urandom);
    @(negedge clk);
    rd1 = 1'b0;
    while (q1.size() - s0 < 20 && t < 200) begin @(negedge clk); t++; end
    n_chk++;
    if (t >= 200) begin n_fail++; $display("FAIL rst_mid timeout: bits %0d want 20", q1.size() - s0); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sel1, busy1, sck1, mosi1} !== 4'b1000 || dout1 !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid async: sel/busy/sck/mosi %b%b%b%b dout %h want 1000 00", sel1, busy1, sck1, mosi1, dout1);
    end
    r0 = rises1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (rises1 != r0 || sel1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid sck_edges: got %0d want %0d", rises1, r0); end
    rst_n = 1'b1;
    @(negedge clk);
    resp1 = 8'($urandom);
    run1(1'b0, 1'b1, 16'($urandom), 8'($urandom), 1'b0, "read_after_rst");
  endtask
  task automatic test_contention;
    resp1 = 8'($urandom);
    run1(1'b1, 1'b1, 16'($urandom), 8'($urandom), 1'b0, "both_starts");
    run1(1'b1, 1'b0, 16'($urandom), 8'($urandom), 1'b1, "read_mid_write");
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy1 !== 1'b0 || sel1 !== 1'b1) begin n_fail++; $display("FAIL ignored_read: busy %b sel %b want 0 1", busy1, sel1); end
  endtask
  task automatic test_multibyte;
    run2(16'h1234, 16'h2211, "mb_fixed");
    repeat (2) run2(16'($urandom), 16'($urandom), "mb_rand");
  endtask
  task automatic test_back_to_back;
    run1(1'b1, 1'b0, 16'($urandom), 8'($urandom), 1'b0, "b2b_write");
    resp1 = 8'($urandom);
    run1(1'b0, 1'b1, 16'($urandom), 8'($urandom), 1'b0, "b2b_read");
    run1(1'b1, 1'b0, 16'($urandom), 8'($urandom), 1'b0, "b2b_write2");
  endtask
  initial begin
    test_reset;
    test_write;
    test_read;
    test_reset_mid_read;
    test_contention;
    test_multibyte;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
